ga_config_irq_ctrl: RTL and testbench

//  Gate Array register file and interrupt scheduler. Decodes Z80 writes to the

---
 rtl/ga_config_irq_ctrl.sv | 131 +++++++++++++
 tb/tb_ga_config_irq_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ga_config_irq_ctrl.sv
// Gate Array register file: decodes Z80 I/O writes into ROM enables, mode, pen and ink,
// and runs the 52-line HSYNC interrupt counter with VSYNC resync and Z80 acknowledge.
module ga_config_irq_ctrl #(
    parameter int IRQ_LINES   = 52,
    parameter int VSYNC_DELAY = 2,
    parameter int CNT_W       = 6
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       IORQ_n,
    input  logic       WR_n,
    input  logic       M1_n,
    input  logic       A15,
    input  logic       A14,
    input  logic [7:0] D,
    input  logic       HSYNC,
    input  logic       VSYNC,
    output logic       INT_n,
    output logic       LROMEN,
    output logic       HROMEN,
    output logic [1:0] MODE,
    output logic [4:0] PEN,
    output logic       INK_WE,
    output logic [4:0] INK_DATA
);
    localparam int DLY_W = $clog2(VSYNC_DELAY + 1);

    logic             r_sel;
    logic             r_ack_cyc;
    logic             r_hs;
    logic             r_vs;
    logic [1:0]       r_pmode;
    logic [CNT_W-1:0] r_r52;
    logic [DLY_W-1:0] r_vdly;

    logic             w_sel;
    logic             w_ack_cyc;
    logic             w_wr;
    logic             w_ack;
    logic             w_hfall;
    logic             w_hrise;
    logic             w_vrise;
    logic             w_clear;
    logic             w_resync;
    logic             w_wrap;
    logic             w_raise;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_unused_d5;

    assign w_sel       = ~IORQ_n & ~WR_n & M1_n & A15 & ~A14;
    assign w_ack_cyc   = ~M1_n & ~IORQ_n;
    assign w_wr        = w_sel & ~r_sel;
    assign w_ack       = w_ack_cyc & ~r_ack_cyc;
    assign w_hfall     = r_hs & ~HSYNC;
    assign w_hrise     = ~r_hs & HSYNC;
    assign w_vrise     = ~r_vs & VSYNC;
    assign w_clear     = w_wr & (D[7:6] == 2'b10) & D[4];
    assign w_unused_d5 = D[5];

    // The HSYNC fall that empties the VSYNC delay resyncs instead of counting.
    assign w_cnt_inc = r_r52 + 1'b1;
    assign w_resync  = w_hfall & (r_vdly == DLY_W'(1));
    assign w_wrap    = w_hfall & ~w_resync & (w_cnt_inc == CNT_W'(IRQ_LINES));
    assign w_raise   = w_wrap | (w_resync & (r_r52 >= CNT_W'(32)));

    always_comb begin
        w_cnt_nxt = r_r52;
        if (w_hfall)
            w_cnt_nxt = (w_resync || w_wrap) ? '0 : w_cnt_inc;
        if (w_ack)
            w_cnt_nxt[CNT_W-1] = 1'b0;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            // Strobe history starts "active" so a cycle straddling reset release
            // must drop and reassert before it counts.
            r_sel     <= 1'b1;
            r_ack_cyc <= 1'b1;
            r_hs      <= 1'b0;
            r_vs      <= 1'b0;
            r_pmode   <= 2'd0;
            r_r52     <= '0;
            r_vdly    <= '0;
            INT_n     <= 1'b1;
            LROMEN    <= 1'b0;
            HROMEN    <= 1'b0;
            MODE      <= 2'd0;
            PEN       <= 5'd0;
            INK_WE    <= 1'b0;
            INK_DATA  <= 5'd0;
        end else begin
            r_sel     <= w_sel;
            r_ack_cyc <= w_ack_cyc;
            r_hs      <= HSYNC;
            r_vs      <= VSYNC;
            INK_WE    <= w_wr & (D[7:6] == 2'b01);

            if (w_hrise)
                MODE <= r_pmode;

            if (w_wr) begin
                case (D[7:6])
                    2'b00: PEN <= D[4:0];
                    2'b01: INK_DATA <= D[4:0];
                    2'b10: begin
                        LROMEN  <= D[2];
                        HROMEN  <= D[3];
                        r_pmode <= D[1:0];
                    end
                    default: ;
                endcase
            end

            r_r52 <= w_clear ? '0 : w_cnt_nxt;

            if (w_vrise)
                r_vdly <= DLY_W'(VSYNC_DELAY);
            else if (w_hfall && (r_vdly != '0))
                r_vdly <= r_vdly - 1'b1;

            if (w_clear)
                INT_n <= 1'b1;
            else if (w_raise)
                INT_n <= 1'b0;
            else if (w_ack)
                INT_n <= 1'b1;
        end
    end
endmodule

// File: tb/tb_ga_config_irq_ctrl.sv
// Scoreboard bench: a per-cycle reference model pushes expected outputs, a monitor pops and compares.
module tb_ga_config_irq_ctrl;
    localparam int IRQ_LINES = 52;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       IORQ_n = 1'b1, WR_n = 1'b1, M1_n = 1'b1, A15 = 1'b0, A14 = 1'b0;
    logic [7:0] D = 8'd0;
    logic       HSYNC = 1'b0, VSYNC = 1'b0;
    logic       INT_n, LROMEN, HROMEN, INK_WE;
    logic [1:0] MODE;
    logic [4:0] PEN, INK_DATA;

    ga_config_irq_ctrl dut (
        .CLK(CLK), .RESET(RESET), .IORQ_n(IORQ_n), .WR_n(WR_n), .M1_n(M1_n),
        .A15(A15), .A14(A14), .D(D), .HSYNC(HSYNC), .VSYNC(VSYNC),
        .INT_n(INT_n), .LROMEN(LROMEN), .HROMEN(HROMEN), .MODE(MODE),
        .PEN(PEN), .INK_WE(INK_WE), .INK_DATA(INK_DATA)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad = 0;
    int ink_pulses = 0;
    logic [15:0] exp_q[$];

    // Stimulus for the next edge
    logic       g_rst = 1'b1, g_iorq = 1'b1, g_wr = 1'b1, g_m1 = 1'b1, g_a15 = 1'b0, g_a14 = 1'b0;
    logic [7:0] g_d = 8'd0;
    logic       g_h = 1'b0, g_v = 1'b0;

    // Reference model state
    int         m_cnt, m_vdly;
    bit         m_intn, m_lrom, m_hrom, m_inkwe;
    logic [1:0] m_mode, m_pmode;
    logic [4:0] m_pen, m_ink;
    bit         m_wr_armed, m_ack_armed, m_prev_h, m_prev_v;

    task automatic model_step();
        bit sel, ackc, wr_now, ack_now, hfall, hrise, vrise, clear, raise;
        int nc;
        if (g_rst) begin
            m_cnt = 0; m_vdly = 0; m_intn = 1; m_lrom = 0; m_hrom = 0; m_inkwe = 0;
            m_mode = 0; m_pmode = 0; m_pen = 0; m_ink = 0;
            m_wr_armed = 0; m_ack_armed = 0; m_prev_h = 0; m_prev_v = 0;
        end else begin
            sel     = !g_iorq && !g_wr && g_m1 && g_a15 && !g_a14;
            ackc    = !g_iorq && !g_m1;
            wr_now  = sel && m_wr_armed;
            ack_now = ackc && m_ack_armed;
            m_wr_armed  = !sel;
            m_ack_armed = !ackc;
            hfall = m_prev_h && !g_h;
            hrise = !m_prev_h && g_h;
            vrise = !m_prev_v && g_v;
            m_prev_h = g_h;
            m_prev_v = g_v;
            clear = wr_now && g_d[7:6] == 2'b10 && g_d[4];
            raise = 0;
            nc = m_cnt;
            if (hfall) begin
                if (m_vdly == 1) begin
                    raise = (m_cnt >= 32);
                    nc = 0;
                end else begin
                    nc = (m_cnt + 1) % IRQ_LINES;
                    raise = (nc == 0);
                end
                if (m_vdly > 0) m_vdly--;
            end
            if (vrise) m_vdly = 2;
            if (hrise) m_mode = m_pmode;
            m_inkwe = wr_now && g_d[7:6] == 2'b01;
            if (wr_now) begin
                case (g_d[7:6])
                    2'b00: m_pen = g_d[4:0];
                    2'b01: m_ink = g_d[4:0];
                    2'b10: begin m_lrom = g_d[2]; m_hrom = g_d[3]; m_pmode = g_d[1:0]; end
                    default: ;
                endcase
            end
            if (ack_now && nc >= 32) nc -= 32;
            m_cnt = clear ? 0 : nc;
            if (clear) m_intn = 1;
            else if (raise) m_intn = 0;
            else if (ack_now) m_intn = 1;
        end
        exp_q.push_back({m_intn, m_lrom, m_hrom, m_mode, m_pen, m_inkwe, m_ink});
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            RESET = g_rst; IORQ_n = g_iorq; WR_n = g_wr; M1_n = g_m1;
            A15 = g_a15; A14 = g_a14; D = g_d; HSYNC = g_h; VSYNC = g_v;
            model_step();
        end
    endtask

    task automatic bus_idle();
        g_iorq = 1; g_wr = 1; g_m1 = 1; g_a15 = 0; g_a14 = 0;
    endtask

    task automatic io_write(input logic [7:0] d, input int hold);
        g_iorq = 0; g_wr = 0; g_m1 = 1; g_a15 = 1; g_a14 = 0; g_d = d;
        cyc(hold);
        bus_idle();
        cyc(1);
    endtask

    task automatic ack_cycle();
        g_iorq = 0; g_wr = 1; g_m1 = 0;
        cyc(2);
        bus_idle();
        cyc(1);
    endtask

    task automatic hpulses(input int n);
        for (int i = 0; i < n; i++) begin
            g_h = 1; cyc(2);
            g_h = 0; cyc(2);
        end
    endtask

    task automatic do_reset();
        bus_idle(); g_h = 0; g_v = 0; g_rst = 1;
        cyc(2);
        g_rst = 0;
        cyc(1);
    endtask

    // Monitor: every output sample is checked against the next queued expectation
    initial begin
        logic [15:0] e, a;
        forever begin
            @(posedge CLK);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {INT_n, LROMEN, HROMEN, MODE, PEN, INK_WE, INK_DATA};
                total++;
                if (a !== e) begin
                    bad++;
                    $display("FAIL outputs t=%0t got={int_n,lrom,hrom,mode,pen,ink_we,ink}=%h expected=%h",
                             $time, a, e);
                end
                if (INK_WE) ink_pulses++;
            end
        end
    end

    initial begin
        int p0, hcnt, hold, mode;
        logic [7:0] rd;

        do_reset();

        // ROM enables immediately, mode only after an HSYNC rise
        io_write(8'h8D, 2);
        cyc(3);
        hpulses(1);

        // 52-line interrupt and acknowledge
        do_reset();
        hpulses(51);
        cyc(2);
        hpulses(1);
        cyc(2);
        ack_cycle();
        cyc(2);

        // VSYNC resync with R52 high, then low
        do_reset();
        hpulses(40);
        g_v = 1; cyc(2);
        hpulses(2);
        g_v = 0; cyc(2);
        ack_cycle();
        do_reset();
        hpulses(20);
        g_v = 1; cyc(2);
        hpulses(2);
        g_v = 0; cyc(2);
        hpulses(51);
        cyc(2);
        hpulses(1);
        ack_cycle();

        // Clear on the same CLK as the wrapping HSYNC fall
        do_reset();
        hpulses(51);
        g_h = 1; cyc(2);
        g_h = 0; g_iorq = 0; g_wr = 0; g_m1 = 1; g_a15 = 1; g_a14 = 0; g_d = 8'h90;
        cyc(2);
        bus_idle(); cyc(2);
        hpulses(52);
        ack_cycle();

        // Held ink write gives one pulse; bank write changes nothing
        p0 = ink_pulses;
        io_write(8'h45, 4);
        cyc(2);
        total++;
        if (ink_pulses - p0 != 1) begin
            bad++;
            $display("FAIL ink_pulse_count got=%0d expected=1", ink_pulses - p0);
        end
        p0 = ink_pulses;
        io_write(8'hC4, 3);
        io_write(8'h0C, 2);
        cyc(2);
        total++;
        if (ink_pulses - p0 != 0) begin
            bad++;
            $display("FAIL ink_pulse_bank got=%0d expected=0", ink_pulses - p0);
        end

        // Reset in the middle of an I/O write, strobe held across release
        g_iorq = 0; g_wr = 0; g_m1 = 1; g_a15 = 1; g_a14 = 0; g_d = 8'h13; g_rst = 1;
        cyc(2);
        g_rst = 0;
        cyc(3);
        bus_idle(); cyc(1);
        io_write(8'h13, 2);

        // Randomized traffic
        hcnt = 0; hold = 0; mode = 0;
        for (int i = 0; i < 4000; i++) begin
            if (hcnt == 0) begin
                g_h = ~g_h;
                hcnt = $urandom_range(1, 4);
            end else hcnt--;
            if ($urandom_range(0, 199) == 0) g_v = ~g_v;
            if (hold == 0) begin
                mode = $urandom_range(0, 7);
                hold = $urandom_range(1, 4);
                bus_idle();
                if (mode >= 3 && mode <= 5) begin
                    rd = 8'($urandom);
                    if (rd[7:6] == 2'b10 && $urandom_range(0, 7) != 0) rd[4] = 1'b0;
                    g_iorq = 0; g_wr = 0; g_m1 = 1; g_d = rd;
                    g_a15 = ($urandom_range(0, 5) != 0);
                    g_a14 = ($urandom_range(0, 5) == 0);
                end else if (mode == 6 && $urandom_range(0, 2) == 0) begin
                    g_iorq = 0; g_m1 = 0;
                end
            end else hold--;
            g_rst = ($urandom_range(0, 1499) == 0);
            cyc(1);
        end
        g_rst = 0;
        bus_idle();
        cyc(3);

        @(posedge CLK);
        #2;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL queue_drain got=%0d expected=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
